// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states
// and the iteration-counter width helper.
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } md_state_e;

    function automatic int md_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on
// the 2*WIDTH accumulator. In divide mode the quotient bit is returned on q_o
// and the accumulator LSB is left 0 for the caller to fill.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               div_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               q_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] trial;
    logic             ge;

    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Remainder shifted left by one; the extra top bit matters only for the compare.
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        ge     = rem_sh >= {1'b0, opnd_i};
        trial  = rem_sh[WIDTH-1:0] - opnd_i;
        if (div_i) begin
            acc_o = {(ge ? trial : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], 1'b0};
            q_o   = ge;
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
            q_o   = 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO. Operands are held
// as magnitudes; sign correction is applied once in FIX before writeback.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_read_hilo,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_HI,
    output logic [WIDTH-1:0] o_LO
);

    localparam int CW = md_cnt_w(WIDTH);
    localparam int W2 = 2 * WIDTH;

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             isdiv_q, isdiv_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic             dzo_q, dzo_d;

    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [W2-1:0]    step_acc, prod_fix;
    logic             step_q;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign signed_op = (i_op == MD_MULT) || (i_op == MD_DIV);
    assign a_neg     = signed_op && i_a[WIDTH-1];
    assign b_neg     = signed_op && i_b[WIDTH-1];
    // Most-negative input maps to 2^(WIDTH-1), which still fits unsigned.
    assign a_mag     = a_neg ? -i_a : i_a;
    assign b_mag     = b_neg ? -i_b : i_b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (isdiv_q),
        .acc_o  (step_acc),
        .q_o    (step_q)
    );

    assign prod_fix = negq_q ? -acc_q : acc_q;
    assign quo_fix  = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = negr_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        isdiv_d = isdiv_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dzo_d   = 1'b0;
        case (state_q)
            IDLE: if (i_start && !i_flush) begin
                case (i_op)
                    MD_MTHI: hi_d = i_a;
                    MD_MTLO: lo_d = i_a;
                    MD_MULT, MD_MULTU: begin
                        state_d = MUL;
                        cnt_d   = CW'(WIDTH - 1);
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = 1'b0;
                        isdiv_d = 1'b0;
                        dz_d    = 1'b0;
                    end
                    MD_DIV, MD_DIVU: if (DIV_EN) begin
                        cnt_d   = CW'(WIDTH - 1);
                        opnd_d  = b_mag;
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = a_neg;
                        isdiv_d = 1'b1;
                        // Divide by zero skips iterating; FIX writes acc_q raw.
                        if (i_b == '0) begin
                            state_d = FIX;
                            dz_d    = 1'b1;
                            acc_d   = {i_a, {WIDTH{1'b1}}};
                        end else begin
                            state_d = DIV;
                            dz_d    = 1'b0;
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                        end
                    end
                    default: ;
                endcase
            end
            MUL, DIV: begin
                if (i_flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc | W2'(step_q);
                    if (cnt_q == '0) state_d = FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!i_flush) begin
                    done_d = 1'b1;
                    dzo_d  = dz_q;
                    if (dz_q)         {hi_d, lo_d} = acc_q;
                    else if (isdiv_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                    else              {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            isdiv_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            isdiv_q <= isdiv_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
        end
    end

    assign o_busy     = (state_q != IDLE);
    assign o_stall    = (i_read_hilo || i_start) && o_busy;
    assign o_done     = done_q;
    assign o_div_zero = dzo_q;
    assign o_HI       = hi_q;
    assign o_LO       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit (WIDTH=32) against a 64-bit
// arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
                           OP_DIVU = 3'd3, OP_MTHI = 3'd4, OP_MTLO = 3'd5;

    logic         clk = 1'b0;
    logic         i_rst, i_start, i_read_hilo, i_flush;
    logic [2:0]   i_op;
    logic [W-1:0] i_a, i_b;
    logic         o_busy, o_stall, o_done, o_div_zero;
    logic [W-1:0] o_HI, o_LO;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W), .DIV_EN(1'b1)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_op        (i_op),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_read_hilo (i_read_hilo),
        .i_flush     (i_flush),
        .o_busy      (o_busy),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_div_zero  (o_div_zero),
        .o_HI        (o_HI),
        .o_LO        (o_LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            OP_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            OP_MULTU: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
                end else if (op == OP_DIV) begin
                    lo = 32'(sa / sb); hi = 32'(sa % sb);
                end else begin
                    lo = 32'(ua / ub); hi = 32'(ua % ub);
                end
            end
            default: ;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] ehi, elo;
        logic        edz;
        int          n;
        model(op, a, b, ehi, elo, edz);
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_a = a; i_b = b;
        @(posedge clk); #1;
        i_start = 1'b0;
        n = 0;
        while (!o_done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, edz ? 1 : W + 1);
        check({tag, "_hi"}, o_HI, ehi);
        check({tag, "_lo"}, o_LO, elo);
        check({tag, "_dz"}, o_div_zero, edz);
        @(posedge clk); #1;
        check({tag, "_pulse"}, o_done, 1'b0);
    endtask

    initial begin
        int          n;
        bit          stall_ok, saw_done;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        i_rst = 1'b1; i_start = 1'b0; i_op = '0; i_a = '0; i_b = '0;
        i_read_hilo = 1'b0; i_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", o_HI, 0);
        check("rst_lo", o_LO, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_dz", o_div_zero, 0);
        i_rst = 1'b0;

        // Moves: zero latency, no busy, no done
        @(negedge clk); i_start = 1'b1; i_op = OP_MTHI; i_a = 32'h1234_5678;
        @(posedge clk); #1; i_start = 1'b0;
        check("mthi_hi", o_HI, 32'h1234_5678);
        check("mthi_busy", o_busy, 0);
        check("mthi_done", o_done, 0);
        @(negedge clk); i_start = 1'b1; i_op = OP_MTLO; i_a = 32'hCAFE_0001;
        @(posedge clk); #1; i_start = 1'b0;
        check("mtlo_lo", o_LO, 32'hCAFE_0001);
        check("mtlo_hi_keep", o_HI, 32'h1234_5678);
        @(negedge clk); i_start = 1'b1; i_op = 3'd6; i_a = 32'hFFFF_0000;
        @(posedge clk); #1; i_start = 1'b0;
        check("op6_busy", o_busy, 0);
        check("op6_lo", o_LO, 32'hCAFE_0001);

        // Directed corner cases
        run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3,         "mult_m2x3");
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         "div_m7d2");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_minneg");
        run_op(OP_DIVU,  32'd5,         32'd0,         "divu_zero");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         "div_zero_neg");
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minneg");

        // Randomized operands with biased corner picks
        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = $urandom_range(1, 9);
                2: ra = 32'h8000_0000;
                3: rb = -32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(rop, ra, rb, $sformatf("rnd%0d", i));
        end

        // Stall while MFHI/MFLO waits; a start during busy is ignored
        @(negedge clk); i_start = 1'b1; i_op = OP_MULT; i_a = 32'd3; i_b = 32'd4;
        @(posedge clk); #1; i_start = 1'b0; i_read_hilo = 1'b1;
        n = 0; stall_ok = 1'b1;
        while (!o_done && n < 100) begin
            if (!o_stall) stall_ok = 1'b0;
            if (n == 5) begin i_start = 1'b1; i_op = OP_MTHI; i_a = 32'hDEAD_BEEF; end
            else i_start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        i_start = 1'b0;
        check("stall_held", stall_ok, 1);
        check("stall_lat", n, W + 1);
        check("stall_done_free", o_stall, 0);
        check("stall_lo", o_LO, 32'd12);
        check("stall_hi", o_HI, 32'd0);
        i_read_hilo = 1'b0;

        // Flush at iteration 10 of a second MULT
        @(negedge clk); i_start = 1'b1; i_op = OP_MULT; i_a = $urandom; i_b = $urandom | 32'd1;
        @(posedge clk); #1; i_start = 1'b0;
        repeat (10) @(posedge clk);
        #1; i_flush = 1'b1;
        @(posedge clk); #1; i_flush = 1'b0;
        check("flush_busy", o_busy, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (o_done) saw_done = 1'b1;
        end
        check("flush_nodone", saw_done, 0);
        check("flush_hi", o_HI, 32'd0);
        check("flush_lo", o_LO, 32'd12);

        // Flush while in FIX (divide by zero path)
        @(negedge clk); i_start = 1'b1; i_op = OP_DIVU; i_a = 32'd7; i_b = 32'd0;
        @(posedge clk); #1; i_start = 1'b0; i_flush = 1'b1;
        @(posedge clk); #1; i_flush = 1'b0;
        check("flushfix_done", o_done, 0);
        check("flushfix_hi", o_HI, 32'd0);
        check("flushfix_lo", o_LO, 32'd12);

        // Flush beats start in IDLE
        @(negedge clk); i_start = 1'b1; i_flush = 1'b1; i_op = OP_MTLO; i_a = 32'h55;
        @(posedge clk); #1;
        check("flushstart_lo", o_LO, 32'd12);
        i_op = OP_MULT; i_a = 32'd2; i_b = 32'd2;
        @(posedge clk); #1; i_start = 1'b0; i_flush = 1'b0;
        check("flushstart_busy", o_busy, 0);

        // Reset mid-DIV
        @(negedge clk); i_start = 1'b1; i_op = OP_DIV; i_a = 32'd100; i_b = 32'd7;
        @(posedge clk); #1; i_start = 1'b0;
        repeat (5) @(posedge clk);
        #1; i_rst = 1'b1;
        @(posedge clk); #1; i_rst = 1'b0;
        check("rstdiv_hi", o_HI, 0);
        check("rstdiv_lo", o_LO, 0);
        check("rstdiv_busy", o_busy, 0);
        check("rstdiv_done", o_done, 0);
        run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, "post_rst_div");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
